jtcontra_romarb: RTL

JTCONTRA_ROMARB -- requirements
Module: jtcontra_romarb

---
 rtl/jtcontra_pkg.sv | 25 ++
 rtl/jtcontra_romarb_entry.sv | 57 +++++
 rtl/jtcontra_romarb.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/jtcontra_pkg.sv
// Shared definitions for the Contra graphics ROM arbiter: FSM encoding,
// settle delay and requester indices.
package jtcontra_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_e;

    localparam logic [1:0] SETTLE   = 2'd2;
    localparam logic       REQ_GFX1 = 1'b0;
    localparam logic       REQ_GFX2 = 1'b1;

    // Grant selection: a lone pending requester wins; on a tie the one not served last wins.
    function automatic logic pick_req(input logic p1, input logic p2, input logic last);
        if (p1 && p2) begin
            return ~last;
        end else if (p2) begin
            return REQ_GFX2;
        end else begin
            return REQ_GFX1;
        end
    endfunction

endpackage

// File: rtl/jtcontra_romarb_entry.sv
// Single-word cache entry for one graphics requester plus its hit compare.
module jtcontra_romarb_entry
    import jtcontra_pkg::*;
#(
    parameter int unsigned AW = 18,
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          flush,
    input  logic          load,
    input  logic          discard,
    input  logic [AW-1:0] load_addr,
    input  logic [DW-1:0] load_data,
    output logic          hit_c,
    output logic [DW-1:0] data
);

    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;

    // A flush always wins over a capture in the same cycle.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (load) begin
            addr_d = load_addr;
            data_d = load_data;
            if (!discard) begin
                valid_d = 1'b1;
            end
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign hit_c = cs & valid_q & (addr_q == addr);
    assign data  = data_q;

endmodule

// File: rtl/jtcontra_romarb.sv
// Two-requester graphics ROM arbiter sharing one SDRAM slot, with a one-word
// cache per requester, stale-ok settle delay and a fetch watchdog.
module jtcontra_romarb
    import jtcontra_pkg::*;
#(
    parameter int unsigned AW   = 18,
    parameter int unsigned DW   = 16,
    parameter int unsigned TOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          gfx1_cs,
    input  logic [AW-1:0] gfx1_addr,
    output logic          gfx1_ok,
    output logic [DW-1:0] gfx1_data,
    input  logic          gfx2_cs,
    input  logic [AW-1:0] gfx2_addr,
    output logic          gfx2_ok,
    output logic [DW-1:0] gfx2_data,
    input  logic          flush,
    output logic          rom_cs,
    output logic [AW:0]   rom_addr,
    input  logic [DW-1:0] rom_data,
    input  logic          rom_ok,
    output logic          timeout
);

    localparam int unsigned WW = $clog2(TOUT + 1);

    arb_state_e    state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_q, last_d;
    logic          rom_cs_q, rom_cs_d;
    logic [AW:0]   rom_addr_q, rom_addr_d;
    logic [1:0]    settle_q, settle_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          timeout_q, timeout_d;
    logic          discard_q, discard_d;
    logic          capture;
    logic          gsel;
    logic          ok1_c, ok2_c;
    logic          pend1, pend2;

    assign pend1 = gfx1_cs & ~ok1_c;
    assign pend2 = gfx2_cs & ~ok2_c;
    assign gsel  = pick_req(pend1, pend2, last_q);

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        rom_cs_d   = rom_cs_q;
        rom_addr_d = rom_addr_q;
        settle_d   = settle_q;
        wdog_d     = wdog_q;
        timeout_d  = 1'b0;
        discard_d  = discard_q;
        capture    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                discard_d = 1'b0;
                if (pend1 || pend2) begin
                    sel_d      = gsel;
                    rom_addr_d = {gsel, (gsel == REQ_GFX2) ? gfx2_addr : gfx1_addr};
                    rom_cs_d   = 1'b1;
                    settle_d   = '0;
                    wdog_d     = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (settle_q != SETTLE) begin
                    settle_d = settle_q + 2'd1;
                end
                wdog_d = wdog_q + WW'(1);
                if (settle_q == SETTLE && rom_ok) begin
                    capture  = 1'b1;
                    rom_cs_d = 1'b0;
                    last_d   = sel_q;
                    state_d  = ST_IDLE;
                end else if (wdog_q == WW'(TOUT - 1)) begin
                    rom_cs_d  = 1'b0;
                    timeout_d = 1'b1;
                    last_d    = sel_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= REQ_GFX1;
            last_q     <= REQ_GFX2;
            rom_cs_q   <= 1'b0;
            rom_addr_q <= '0;
            settle_q   <= '0;
            wdog_q     <= '0;
            timeout_q  <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            rom_cs_q   <= rom_cs_d;
            rom_addr_q <= rom_addr_d;
            settle_q   <= settle_d;
            wdog_q     <= wdog_d;
            timeout_q  <= timeout_d;
            discard_q  <= discard_d;
        end
    end

    jtcontra_romarb_entry #(.AW(AW), .DW(DW)) u_gfx1 (
        .clk       (clk),
        .rst       (rst),
        .cs        (gfx1_cs),
        .addr      (gfx1_addr),
        .flush     (flush),
        .load      (capture && sel_q == REQ_GFX1),
        .discard   (discard_q),
        .load_addr (rom_addr_q[AW-1:0]),
        .load_data (rom_data),
        .hit_c     (ok1_c),
        .data      (gfx1_data)
    );

    jtcontra_romarb_entry #(.AW(AW), .DW(DW)) u_gfx2 (
        .clk       (clk),
        .rst       (rst),
        .cs        (gfx2_cs),
        .addr      (gfx2_addr),
        .flush     (flush),
        .load      (capture && sel_q == REQ_GFX2),
        .discard   (discard_q),
        .load_addr (rom_addr_q[AW-1:0]),
        .load_data (rom_data),
        .hit_c     (ok2_c),
        .data      (gfx2_data)
    );

    assign gfx1_ok  = ok1_c;
    assign gfx2_ok  = ok2_c;
    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;
    assign timeout  = timeout_q;

endmodule
